// File: rtl/wb_pkg.sv
// Shared Wishbone B4 definitions for the arbiter and watchdog.
// Bus widths and the arbiter state encoding.
package wb_pkg;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1
  } arb_state_t;

endpackage

// File: rtl/wb4_if.sv
// Wishbone B4 classic/pipelined signal bundle.
// master drives ADR/DAT_O/WE/CYC/STB, slave drives DAT_I/ACK.
interface wb4_if;
  import wb_pkg::*;

  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_o;
  logic [DAT_W-1:0] dat_i;
  logic             we;
  logic             cyc;
  logic             stb;
  logic             ack;

  modport master (
    output adr, dat_o, we, cyc, stb,
    input  dat_i, ack
  );

  modport slave (
    input  adr, dat_o, we, cyc, stb,
    output dat_i, ack
  );

endinterface

// File: rtl/wb_watchdog.sv
// Strobe watchdog: counts unacknowledged cycles.
// expire is high while the count sits at LIMIT-1.
module wb_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/wb_arbiter.sv
// Two-master round-robin Wishbone B4 arbiter.
// Grant held for a whole CYC; stuck strobes are force-acked.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned      TIMEOUT_CYCLES = 255,
  parameter logic [DAT_W-1:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic             clk,
  input  logic             rst,
  wb4_if.slave             m0,
  wb4_if.slave             m1,
  wb4_if.master            bus,
  output logic             timeout_o,
  output logic [ADR_W-1:0] timeout_adr_o,
  output logic [1:0]       grant_o
);

  arb_state_t       state_q, state_d;
  logic             last_q, last_d;
  logic [ADR_W-1:0] tadr_q, tadr_d;

  logic             req0, req1;
  logic             g0, g1, gnt;
  logic             sel_cyc, sel_stb, sel_we;
  logic [ADR_W-1:0] sel_adr;
  logic [DAT_W-1:0] sel_dat;
  logic             bus_stb;
  logic             expire, to;
  logic             rsp_ack;
  logic [DAT_W-1:0] rsp_dat;
  logic             wd_clr, wd_inc;

  assign req0 = m0.cyc & m0.stb;
  assign req1 = m1.cyc & m1.stb;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req0 && (!req1 || last_q)) begin
          state_d = GNT0;
        end else if (req1) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!m0.cyc) begin
          state_d = req1 ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1.cyc) begin
          state_d = req0 ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == GNT0 && state_q != GNT0) begin
      last_d = 1'b0;
    end
    if (state_d == GNT1 && state_q != GNT1) begin
      last_d = 1'b1;
    end
  end

  // Reset also masks the grant so an interrupted master sees no ACK.
  assign g0  = !rst && (state_q == GNT0);
  assign g1  = !rst && (state_q == GNT1);
  assign gnt = g0 | g1;

  always_comb begin
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    sel_we  = 1'b0;
    sel_adr = '0;
    sel_dat = '0;
    unique case (1'b1)
      g0: begin
        sel_cyc = m0.cyc;
        sel_stb = m0.stb;
        sel_we  = m0.we;
        sel_adr = m0.adr;
        sel_dat = m0.dat_o;
      end
      g1: begin
        sel_cyc = m1.cyc;
        sel_stb = m1.stb;
        sel_we  = m1.we;
        sel_adr = m1.adr;
        sel_dat = m1.dat_o;
      end
      default: ;
    endcase
  end

  assign to      = gnt & sel_stb & !bus.ack & expire;
  assign bus_stb = sel_stb & !to;
  assign rsp_ack = (bus.ack & bus_stb) | to;
  assign rsp_dat = to ? TIMEOUT_DATA : bus.dat_i;

  assign bus.cyc   = sel_cyc;
  assign bus.stb   = bus_stb;
  assign bus.we    = sel_we;
  assign bus.adr   = sel_adr;
  assign bus.dat_o = sel_dat;

  assign m0.ack   = g0 & rsp_ack;
  assign m0.dat_i = g0 ? rsp_dat : '0;
  assign m1.ack   = g1 & rsp_ack;
  assign m1.dat_i = g1 ? rsp_dat : '0;

  assign wd_inc = gnt & sel_stb & !bus.ack;
  assign wd_clr = !gnt | !sel_stb | bus.ack | to
                | (state_d != state_q);

  wb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wd (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .inc    (wd_inc),
    .expire (expire)
  );

  assign tadr_d = to ? sel_adr : tadr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      tadr_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      tadr_q  <= tadr_d;
    end
  end

  assign timeout_o     = to;
  assign timeout_adr_o = tadr_q;
  assign grant_o       = {g1, g0};

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed table-driven bench for wb_arbiter.
// One vector per clock, outputs sampled mid-cycle.
module tb_wb_arbiter;

  localparam logic [31:0] TDAT = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        to_o;
  logic [31:0] tadr_o;
  logic [1:0]  gnt_o;

  wb4_if m0_if ();
  wb4_if m1_if ();
  wb4_if bus_if ();

  wb_arbiter #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .m0            (m0_if),
    .m1            (m1_if),
    .bus           (bus_if),
    .timeout_o     (to_o),
    .timeout_adr_o (tadr_o),
    .grant_o       (gnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        c0, s0, w0;
    logic [31:0] a0;
    logic        c1, s1, w1;
    logic [31:0] a1;
    logic        ack;
    logic [31:0] bdat;
    logic        chk;
    logic        ecyc, estb;
    logic [1:0]  egnt;
    logic        ea0, ea1, eto;
    logic [31:0] eta;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic add(
    input logic r,
    input logic c0, input logic s0, input logic w0,
    input logic [31:0] a0,
    input logic c1, input logic s1, input logic w1,
    input logic [31:0] a1,
    input logic ack, input logic [31:0] bdat,
    input logic chk, input logic ecyc, input logic estb,
    input logic [1:0] egnt,
    input logic ea0, input logic ea1, input logic eto,
    input logic [31:0] eta
  );
    vec_t v;
    v = '{r, c0, s0, w0, a0, c1, s1, w1, a1, ack, bdat,
          chk, ecyc, estb, egnt, ea0, ea1, eto, eta};
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst          = v.rst;
    m0_if.cyc    = v.c0;
    m0_if.stb    = v.s0;
    m0_if.we     = v.w0;
    m0_if.adr    = v.a0;
    m0_if.dat_o  = ~v.a0;
    m1_if.cyc    = v.c1;
    m1_if.stb    = v.s1;
    m1_if.we     = v.w1;
    m1_if.adr    = v.a1;
    m1_if.dat_o  = ~v.a1;
    bus_if.ack   = v.ack;
    bus_if.dat_i = v.bdat;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    logic        ewe;
    logic [31:0] eadr, edo, ed0, ed1;
    logic [167:0] act, exp;
    ewe  = v.egnt == 2'b01 ? v.w0 : v.egnt == 2'b10 ? v.w1 : 1'b0;
    eadr = v.egnt == 2'b01 ? v.a0 : v.egnt == 2'b10 ? v.a1 : 32'h0;
    edo  = v.egnt == 2'b00 ? 32'h0 : ~eadr;
    ed0  = v.egnt[0] ? (v.eto ? TDAT : v.bdat) : 32'h0;
    ed1  = v.egnt[1] ? (v.eto ? TDAT : v.bdat) : 32'h0;
    act  = {bus_if.cyc, bus_if.stb, bus_if.we, bus_if.adr,
            bus_if.dat_o, gnt_o, m0_if.ack, m0_if.dat_i,
            m1_if.ack, m1_if.dat_i, to_o, tadr_o};
    exp  = {v.ecyc, v.estb, ewe, eadr, edo, v.egnt,
            v.ea0, ed0, v.ea1, ed1, v.eto, v.eta};
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL vec%0d: got %h want %h", idx, act, exp);
    end
  endtask

  initial begin
    // reset and idle
    add(1, 0,0,0,0, 0,0,0,0, 0,0, 0, 0,0,2'b00, 0,0,0,0);
    add(1, 0,0,0,0, 0,0,0,0, 0,0, 1, 0,0,2'b00, 0,0,0,0);
    add(0, 0,0,0,0, 0,0,0,0, 0,0, 1, 0,0,2'b00, 0,0,0,0);
    // m0 alone reads 0x10, ACK on 2nd cycle
    add(0, 1,1,0,'h10, 0,0,0,0, 0,0, 1, 0,0,2'b00, 0,0,0,0);
    add(0, 1,1,0,'h10, 0,0,0,0, 0,0, 1, 1,1,2'b01, 0,0,0,0);
    add(0, 1,1,0,'h10, 0,0,0,0, 1,'h1234_5678, 1,
        1,1,2'b01, 1,0,0,0);
    add(0, 0,0,0,0, 0,0,0,0, 0,0, 1, 0,0,2'b01, 0,0,0,0);
    add(0, 0,0,0,0, 0,0,0,0, 0,0, 1, 0,0,2'b00, 0,0,0,0);
    // tie after reset: m0 first, m1 follows without a gap
    add(1, 0,0,0,0, 0,0,0,0, 0,0, 1, 0,0,2'b00, 0,0,0,0);
    add(0, 1,1,0,'h20, 1,1,0,'h30, 0,0, 1, 0,0,2'b00, 0,0,0,0);
    add(0, 1,1,0,'h20, 1,1,0,'h30, 1,'hA, 1, 1,1,2'b01, 1,0,0,0);
    add(0, 0,0,0,0, 1,1,0,'h30, 0,0, 1, 0,0,2'b01, 0,0,0,0);
    add(0, 0,0,0,0, 1,1,0,'h30, 1,'hB, 1, 1,1,2'b10, 0,1,0,0);
    add(0, 0,0,0,0, 0,0,0,0, 0,0, 1, 0,0,2'b10, 0,0,0,0);
    // second tie with m1 last: m0 wins
    add(0, 1,1,0,'h20, 1,1,0,'h30, 0,0, 1, 0,0,2'b00, 0,0,0,0);
    add(0, 1,1,0,'h20, 1,1,0,'h30, 0,0, 1, 1,1,2'b01, 0,0,0,0);
    add(0, 0,0,0,0, 1,1,0,'h30, 0,0, 1, 0,0,2'b01, 0,0,0,0);
    // m1 4-strobe write burst, m0 blocked
    for (int i = 0; i < 4; i++) begin
      add(0, 1,1,0,'h40, 1,1,1,32'h0100_0000 + 32'(4*i),
          1, 32'h100 + 32'(i), 1, 1,1,2'b10, 0,1,0,0);
    end
    add(0, 1,1,0,'h40, 0,0,0,0, 0,0, 1, 0,0,2'b10, 0,0,0,0);
    // m0 stuck strobe, timeout on 8th STB cycle
    for (int i = 0; i < 7; i++) begin
      add(0, 1,1,0,'h40, 0,0,0,0, 0,0, 1, 1,1,2'b01, 0,0,0,0);
    end
    add(0, 1,1,0,'h40, 0,0,0,0, 0,0, 1, 1,0,2'b01, 1,0,1,0);
    add(0, 1,0,0,'h40, 0,0,0,0, 1,'h5555_0000, 1,
        1,0,2'b01, 0,0,0,'h40);
    // real ACK on the timeout cycle wins
    for (int i = 0; i < 7; i++) begin
      add(0, 1,1,0,'h50, 0,0,0,0, 0,0, 1,
          1,1,2'b01, 0,0,0,'h40);
    end
    add(0, 1,1,0,'h50, 0,0,0,0, 1,'hCAFE_0001, 1,
        1,1,2'b01, 1,0,0,'h40);
    // reset while m1 owns the bus
    add(0, 0,0,0,0, 1,1,0,'h60, 0,0, 1, 0,0,2'b01, 0,0,0,'h40);
    add(0, 0,0,0,0, 1,1,0,'h60, 0,0, 1, 1,1,2'b10, 0,0,0,'h40);
    add(1, 1,1,0,'h70, 1,1,0,'h60, 1,'h66, 0,
        0,0,2'b00, 0,0,0,0);
    add(0, 1,1,0,'h70, 1,1,0,'h60, 1,'h66, 1,
        0,0,2'b00, 0,0,0,0);
    add(0, 1,1,0,'h70, 1,1,0,'h60, 1,'h77, 1,
        1,1,2'b01, 1,0,0,0);
    add(0, 0,0,0,0, 0,0,0,0, 0,0, 1, 0,0,2'b01, 0,0,0,0);

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      drive(tbl[i]);
      #4;
      if (tbl[i].chk) check_vec(i, tbl[i]);
    end

    // m1 stuck strobe: bounded wait for the forced ACK
    begin
      vec_t v;
      int   n;
      bit   seen;
      v = '{0, 0,0,0,0, 1,1,0,'h80, 0,0,
            0, 0,0,2'b00, 0,0,0,0};
      @(posedge clk);
      #1;
      drive(v);
      #4;
      chk("m1_idle_gnt", 32'(gnt_o), 32'h0);
      n    = 0;
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(posedge clk);
        #5;
        n++;
        if (to_o) seen = 1;
      end
      chk("m1_to_seen", 32'(seen), 32'h1);
      chk("m1_to_cycle", 32'(n), 32'd8);
      chk("m1_to_gnt", 32'(gnt_o), 32'h2);
      chk("m1_to_ack", 32'(m1_if.ack), 32'h1);
      chk("m1_to_dat", m1_if.dat_i, TDAT);
      chk("m1_to_stb", 32'(bus_if.stb), 32'h0);
      chk("m1_to_m0ack", 32'(m0_if.ack), 32'h0);
      @(posedge clk);
      #1;
      m1_if.cyc = 1'b0;
      m1_if.stb = 1'b0;
      #4;
      chk("m1_to_adr", tadr_o, 32'h80);
      chk("m1_to_pulse", 32'(to_o), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
